dmem_responder: RTL

Data-memory responder serving the load/store requests issued by the pipeline's MEM stage. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and performs byte/half/word stores with lane masking. It returns sign- or zero-extended load data with a one-cycle response pulse. The pipeline holds its EX/MEM register while `req_ready` is low, so the responder sits directly behind that register in place of a zero-latency memory.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module dmem_responder #(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned WORDS = 1 << (DM_ADDRESS - 2);
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  lat_we;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_funct3;

  logic [DATA_W-1:0]     mem [WORDS];

  logic                  acc_we;
  logic [DM_ADDRESS-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [2:0]            acc_funct3;
  logic [DM_ADDRESS-3:0] widx;
  logic [DATA_W-1:0]     word;
  logic [DATA_W-1:0]     shifted;
  logic [1:0]            lane;
  logic [1:0]            size;
  logic                  uns;
  logic                  illegal;
  logic                  misalign;
  logic                  err_c;
  logic [DATA_W-1:0]     rdata_c;
  logic [3:0]            be_c;
  logic [DATA_W-1:0]     wword_c;
  logic                  do_access;

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = S_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, before the latch is loaded
  assign acc_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
  assign acc_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign widx       = acc_addr[DM_ADDRESS-1:2];
  assign word       = mem[widx];
  assign do_access  = (state_next == S_RESP) && (state != S_RESP) && reset;

  // Access decode: legality, lane selection, load extension and store byte enables
  always_comb begin
    size     = acc_funct3[1:0];
    uns      = acc_funct3[2];
    lane     = acc_addr[1:0];
    illegal  = (size == 2'b11) || (uns && (acc_we || (size == 2'b10)));
    misalign = 1'b0;
    err_c    = 1'b0;
    rdata_c  = '0;
    be_c     = '0;
    wword_c  = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
`else
    if (size == 2'b01) lane[0] = 1'b0;
    if (size == 2'b10) lane    = 2'b00;
`endif
    shifted = word >> {lane, 3'b000};
    if (illegal || misalign) begin
      err_c = 1'b1;
    end else if (acc_we) begin
      case (size)
        2'b00: begin
          be_c    = 4'b0001 << lane;
          wword_c = {4{acc_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << lane;
          wword_c = {2{acc_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wword_c = acc_wdata;
        end
      endcase
    end else begin
      case (size)
        2'b00:   rdata_c = {{(DATA_W-8){shifted[7] & ~uns}}, shifted[7:0]};
        2'b01:   rdata_c = {{(DATA_W-16){shifted[15] & ~uns}}, shifted[15:0]};
        default: rdata_c = word;
      endcase
    end
  end

  // Storage: not reset, written only on the edge entering RESP
  always_ff @(posedge clk) begin
    if (do_access) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[widx][8*b +: 8] <= wword_c[8*b +: 8];
      end
    end
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == S_IDLE);
      busy      <= (state_next != S_IDLE);
      rsp_valid <= do_access;
      if ((state == S_IDLE) && req_valid) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end
      if (do_access) begin
        rsp_rdata <= rdata_c;
        rsp_err   <= err_c;
      end
    end
  end

endmodule
